// File: rtl/round_robin_select.sv
// Round-robin arbiter: one grant at a time with a tenure limit and a release turnaround cycle.
// Ports: Clock, ResetN (sync, active-low), Request[N], Done -> GrantAddr, GrantEnable, Busy, Timeout.
module round_robin_select #(
    parameter int ADDR_WIDTH = 2,
    parameter int HOLD_MAX   = 15
) (
    input  logic                       Clock,
    input  logic                       ResetN,
    input  logic [(2**ADDR_WIDTH)-1:0] Request,
    input  logic                       Done,
    output logic [ADDR_WIDTH-1:0]      GrantAddr,
    output logic                       GrantEnable,
    output logic                       Busy,
    output logic                       Timeout
);

    localparam int N  = 2**ADDR_WIDTH;
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [CW-1:0] SAT   = CW'(HOLD_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_to;

    state_t                w_state;
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [CW-1:0]         w_cnt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_en;
    logic                  w_busy;
    logic                  w_to;

    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_win;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_own;
    logic                  w_limit;

    // Search downward so the requester closest to the pointer is written last.
    always_comb begin
        w_any = |Request;
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = r_ptr + ADDR_WIDTH'(k);
            if (Request[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    assign w_own   = Request[r_addr];
    assign w_limit = (HOLD_MAX > 0) && (r_cnt == LIMIT);

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_addr  = r_addr;
        w_en    = 1'b0;
        w_busy  = 1'b0;
        w_to    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state = S_GRANT;
                    w_addr  = w_win;
                    w_cnt   = '0;
                    w_en    = 1'b1;
                    w_busy  = 1'b1;
                end
            end
            S_GRANT: begin
                w_busy = 1'b1;
                if (!w_own || Done || w_limit) begin
                    w_state = S_RELEASE;
                    w_ptr   = r_addr + 1'b1;
                    // Timeout only when the tenure limit was the sole reason.
                    w_to    = w_limit && w_own && !Done;
                end else begin
                    w_en = 1'b1;
                    if (r_cnt != SAT) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if (w_any) begin
                    w_state = S_GRANT;
                    w_addr  = w_win;
                    w_cnt   = '0;
                    w_en    = 1'b1;
                    w_busy  = 1'b1;
                end else begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_to    <= w_to;
        end
    end

    assign GrantAddr   = r_addr;
    assign GrantEnable = r_en;
    assign Busy        = r_busy;
    assign Timeout     = r_to;

endmodule

// File: tb/tb_round_robin_select.sv
// Bench for round_robin_select: directed scenarios plus random traffic
// checked against a cycle-level arbitration model.
module tb_round_robin_select;

    localparam int AW = 2;
    localparam int HM = 4;
    localparam int N  = 4;

    logic          Clock   = 1'b0;
    logic          ResetN  = 1'b0;
    logic [N-1:0]  Request = '0;
    logic          Done    = 1'b0;
    logic [AW-1:0] GrantAddr;
    logic          GrantEnable;
    logic          Busy;
    logic          Timeout;

    round_robin_select #(.ADDR_WIDTH(AW), .HOLD_MAX(HM)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Request    (Request),
        .Done       (Done),
        .GrantAddr  (GrantAddr),
        .GrantEnable(GrantEnable),
        .Busy       (Busy),
        .Timeout    (Timeout)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Model: 0 idle, 1 grant, 2 release; m_ten = grant cycles already completed.
    int   m_state = 0;
    int   m_ptr   = 0;
    int   m_ten   = 0;
    int   m_addr  = 0;
    logic m_en    = 1'b0;
    logic m_busy  = 1'b0;
    logic m_to    = 1'b0;

    function automatic int win(int p, logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic model(input logic [N-1:0] r, input logic d, input logic rn);
        logic lim;
        logic own;
        if (!rn) begin
            m_state = 0; m_ptr = 0; m_ten = 0; m_addr = 0;
            m_en = 0; m_busy = 0; m_to = 0;
            return;
        end
        m_to = 0;
        case (m_state)
            0, 2: begin
                if (r != 0) begin
                    m_state = 1; m_addr = win(m_ptr, r); m_ten = 0;
                    m_en = 1; m_busy = 1;
                end else begin
                    m_state = 0; m_en = 0; m_busy = 0;
                end
            end
            default: begin
                lim = (HM > 0) && (m_ten + 1 >= HM);
                own = r[m_addr];
                if (!own || d || lim) begin
                    m_state = 2; m_en = 0; m_busy = 1;
                    m_to = lim && own && !d;
                    m_ptr = (m_addr + 1) % N;
                end else begin
                    m_ten = m_ten + 1;
                end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic d, input logic rn, input string tag);
        Request = r;
        Done    = d;
        ResetN  = rn;
        @(posedge Clock);
        model(r, d, rn);
        #1;
        chk({tag, "_addr"}, 32'(GrantAddr), 32'(m_addr));
        chk({tag, "_en"}, 32'(GrantEnable), 32'(m_en));
        chk({tag, "_busy"}, 32'(Busy), 32'(m_busy));
        chk({tag, "_to"}, 32'(Timeout), 32'(m_to));
    endtask

    initial begin
        logic [N-1:0] rr;
        logic         dd;
        logic         rn;

        step('0, 0, 0, "reset");
        step('0, 0, 0, "reset");
        chk("reset_en_const", 32'(GrantEnable), 0);

        // Two requesters held: tenure limit then hand-over to requester 2.
        step(4'b0101, 0, 1, "tmo");
        chk("tmo_first_addr", 32'(GrantAddr), 0);
        chk("tmo_first_en", 32'(GrantEnable), 1);
        for (int i = 0; i < 3; i++) step(4'b0101, 0, 1, "tmo");
        chk("tmo_still_en", 32'(GrantEnable), 1);
        step(4'b0101, 0, 1, "tmo");
        chk("tmo_pulse", 32'(Timeout), 1);
        chk("tmo_rel_en", 32'(GrantEnable), 0);
        step(4'b0101, 0, 1, "tmo");
        chk("tmo_next_addr", 32'(GrantAddr), 2);
        for (int i = 0; i < 6; i++) step(4'b0101, 0, 1, "tmo");

        // Done while idle is ignored.
        step('0, 0, 0, "rst2");
        for (int i = 0; i < 3; i++) step('0, 1, 1, "idle_done");
        chk("idle_done_busy", 32'(Busy), 0);

        // Single requester 3, Done on second grant cycle, pointer wraps.
        for (int i = 0; i < 6; i++) begin
            dd = (m_state == 1 && m_ten == 1);
            step(4'b1000, dd, 1, "wrap");
        end
        for (int i = 0; i < 2; i++) step('0, 0, 1, "wrap_idle");
        step(4'b0011, 0, 1, "wrap_chk");
        chk("wrap_ptr0", 32'(GrantAddr), 0);

        // All request, Done on first grant cycle: strict rotation.
        for (int i = 0; i < 16; i++) begin
            dd = (m_state == 1 && m_ten == 0);
            step(4'b1111, dd, 1, "rot");
        end

        // Owner drops its request mid-grant.
        for (int i = 0; i < 3; i++) step('0, 0, 1, "drop_pre");
        step(4'b0010, 0, 1, "drop");
        step(4'b0010, 0, 1, "drop");
        step(4'b0000, 0, 1, "drop_rel");
        chk("drop_to", 32'(Timeout), 0);

        // Reset during a grant to requester 3.
        for (int i = 0; i < 20; i++) begin
            if (m_state == 1 && m_addr == 3) break;
            dd = (m_state == 1 && m_ten == 0);
            step(4'b1111, dd, 1, "pre_rst");
        end
        chk("pre_rst_addr3", 32'(GrantAddr), 3);
        step(4'b1111, 0, 0, "mid_rst");
        chk("mid_rst_en", 32'(GrantEnable), 0);
        step(4'b1111, 0, 1, "post_rst");
        chk("post_rst_addr", 32'(GrantAddr), 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rr = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0 && m_state == 1) rr[m_addr] = 1'b1;
            dd = ($urandom_range(0, 5) == 0);
            rn = ($urandom_range(0, 60) != 0);
            step(rr, dd, rn, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
